ttt_turn_controller: RTL

TTT_TURN_CONTROLLER -- requirements
Module: ttt_turn_controller

---
 rtl/ttt_turn_controller.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ttt_turn_controller.sv
// ttt_turn_controller
// Referee for a two-player tic-tac-toe game. It keeps both players' boards,
// decides whose turn it is, accepts or rejects moves, enforces a per-turn
// time limit, and reports the game result.
//
// Parameters
//   TIMEOUT     clock cycles a player may spend on one turn before forfeiting
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; returns everything to IDLE / empty
//   start       new-game request (honoured in IDLE and DONE only)
//   p1_valid    player-1 move request, square in p1_pos (1..9 legal)
//   p2_valid    player-2 move request, square in p2_pos (1..9 legal)
//   p1_board    player-1 occupancy, bit k = square k+1
//   p2_board    player-2 occupancy, same mapping
//   turn        0 = player 1 to move, 1 = player 2 to move
//   move_ack    one-cycle pulse after a legal move is taken
//   illegal     one-cycle pulse after the current mover's request is rejected
//   win         00 none, 01 player 1, 10 player 2, 11 draw
//   state       IDLE=0, P1_TURN=1, P2_TURN=2, CHECK=3, DONE=4
//   move_count  legal moves placed in the current game

module ttt_turn_controller #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_valid,
  input  logic [3:0] p1_pos,
  input  logic       p2_valid,
  input  logic [3:0] p2_pos,
  output logic [8:0] p1_board,
  output logic [8:0] p2_board,
  output logic       turn,
  output logic       move_ack,
  output logic       illegal,
  output logic [1:0] win,
  output logic [2:0] state,
  output logic [3:0] move_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P1_TURN = 3'd1,
    P2_TURN = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [15:0] TIMER_LAST = TIMEOUT - 16'd1;

  state_t      cur_state, nxt_state;
  logic [15:0] timer, timer_nxt;
  logic [8:0]  p1_board_nxt, p2_board_nxt;
  logic        turn_nxt, move_ack_nxt, illegal_nxt;
  logic [1:0]  win_nxt;
  logic [3:0]  move_count_nxt;

  logic        mover_valid;
  logic [3:0]  mover_pos;
  logic        pos_in_range;
  logic [8:0]  pos_bit;
  logic        legal;
  logic [8:0]  check_board;

  // True when the board holds any of the eight winning lines.
  function automatic logic has_line(input logic [8:0] b);
    logic [8:0] lines [8];
    logic found;
    lines[0] = 9'b000_000_111;  // 1 2 3
    lines[1] = 9'b000_111_000;  // 4 5 6
    lines[2] = 9'b111_000_000;  // 7 8 9
    lines[3] = 9'b001_001_001;  // 1 4 7
    lines[4] = 9'b010_010_010;  // 2 5 8
    lines[5] = 9'b100_100_100;  // 3 6 9
    lines[6] = 9'b100_010_001;  // 1 5 9
    lines[7] = 9'b001_010_100;  // 3 5 7
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((b & lines[i]) == lines[i]) found = 1'b1;
    end
    return found;
  endfunction

  // Only the player whose turn it is gets looked at; the other request
  // lines are simply not selected. The shifted bit for an out-of-range
  // square is harmless because pos_in_range gates it.
  always_comb begin
    mover_valid  = (cur_state == P1_TURN) ? p1_valid : p2_valid;
    mover_pos    = (cur_state == P1_TURN) ? p1_pos   : p2_pos;
    pos_in_range = (mover_pos >= 4'd1) && (mover_pos <= 4'd9);
    pos_bit      = 9'd1 << (mover_pos - 4'd1);
    legal        = mover_valid && pos_in_range &&
                   (((p1_board | p2_board) & pos_bit) == 9'd0);
    check_board  = turn ? p2_board : p1_board;
  end

  // Next-state and next-output logic. Pulses default low; everything else
  // holds unless a state below changes it. In a turn state a legal move
  // beats the timeout, and a timeout beats reporting an illegal request
  // (the game is over, so no rejection pulse is produced on that edge).
  always_comb begin
    nxt_state      = cur_state;
    timer_nxt      = timer;
    p1_board_nxt   = p1_board;
    p2_board_nxt   = p2_board;
    turn_nxt       = turn;
    move_ack_nxt   = 1'b0;
    illegal_nxt    = 1'b0;
    win_nxt        = win;
    move_count_nxt = move_count;

    case (cur_state)
      IDLE, DONE: begin
        if (start) begin
          p1_board_nxt   = 9'd0;
          p2_board_nxt   = 9'd0;
          win_nxt        = 2'b00;
          move_count_nxt = 4'd0;
          timer_nxt      = 16'd0;
          turn_nxt       = 1'b0;
          nxt_state      = P1_TURN;
        end
      end

      P1_TURN, P2_TURN: begin
        if (legal) begin
          if (cur_state == P1_TURN) p1_board_nxt = p1_board | pos_bit;
          else                      p2_board_nxt = p2_board | pos_bit;
          move_count_nxt = move_count + 4'd1;
          timer_nxt      = 16'd0;
          move_ack_nxt   = 1'b1;
          nxt_state      = CHECK;
        end else if (timer == TIMER_LAST) begin
          win_nxt   = (cur_state == P1_TURN) ? 2'b10 : 2'b01;
          nxt_state = DONE;
        end else begin
          timer_nxt   = timer + 16'd1;
          illegal_nxt = mover_valid;
        end
      end

      // The mover's board is judged here; a completed line outranks the
      // full-board draw, so a winning ninth move is a win.
      CHECK: begin
        if (has_line(check_board)) begin
          win_nxt   = turn ? 2'b10 : 2'b01;
          nxt_state = DONE;
        end else if (move_count == 4'd9) begin
          win_nxt   = 2'b11;
          nxt_state = DONE;
        end else begin
          turn_nxt  = ~turn;
          nxt_state = turn ? P1_TURN : P2_TURN;
        end
      end

      default: nxt_state = IDLE;
    endcase
  end

  // State and output registers; reset wins over every other request.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= IDLE;
      timer      <= 16'd0;
      p1_board   <= 9'd0;
      p2_board   <= 9'd0;
      turn       <= 1'b0;
      move_ack   <= 1'b0;
      illegal    <= 1'b0;
      win        <= 2'b00;
      move_count <= 4'd0;
    end else begin
      cur_state  <= nxt_state;
      timer      <= timer_nxt;
      p1_board   <= p1_board_nxt;
      p2_board   <= p2_board_nxt;
      turn       <= turn_nxt;
      move_ack   <= move_ack_nxt;
      illegal    <= illegal_nxt;
      win        <= win_nxt;
      move_count <= move_count_nxt;
    end
  end

  assign state = cur_state;

endmodule
